// File: rtl/dmni_rx_buffer_pkg.sv
// Shared definitions for the DMNI receive front-end: arbiter state encoding
// and the channel-index width helper used to size channel_o.
package DMNIPkg;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_LOCKED = 1'b1
    } rx_arb_state_t;

    // A single channel still needs a 1-bit index so channel_o never collapses to zero width.
    function automatic int ch_idx_width(input int n_channels);
        return (n_channels > 1) ? $clog2(n_channels) : 1;
    endfunction

endpackage

// File: rtl/dmni_rx_buffer_fifo.sv
// Generic synchronous FIFO (rx_channel_fifo) used for per-channel flit and
// timestamp storage; pointers carry one extra wrap bit to tell full from empty.
module rx_channel_fifo #(
    parameter int DATA_SIZE = 33,
    parameter int DEPTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 pop_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dmni_rx_buffer.sv
// Multi-channel Hermes receive buffer with packet-atomic round-robin merge onto
// one DMA stream. Define DMNI_RX_TIMESTAMP_EN to build per-channel timestamp FIFOs.
module dmni_rx_buffer
    import DMNIPkg::*;
#(
    parameter int N_CHANNELS  = 2,
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 16,
    parameter int TS_DEPTH    = ((BUFFER_SIZE / 4) > 2) ? (BUFFER_SIZE / 4) : 2,
    parameter int TS_WIDTH    = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [TS_WIDTH-1:0]                    tick_counter_i,
    input  logic [N_CHANNELS-1:0]                  rx_i,
    input  logic [N_CHANNELS-1:0]                  eop_i,
    output logic [N_CHANNELS-1:0]                  credit_o,
    input  logic [N_CHANNELS*FLIT_SIZE-1:0]        data_i,
    output logic                                   tx_o,
    output logic                                   eop_o,
    input  logic                                   ack_i,
    output logic [FLIT_SIZE-1:0]                   data_o,
    output logic [ch_idx_width(N_CHANNELS)-1:0]    channel_o,
    output logic [TS_WIDTH-1:0]                    timestamp_o,
    output logic                                   pkt_done_o
);

    localparam int CW = ch_idx_width(N_CHANNELS);

    logic [N_CHANNELS-1:0] flit_full;
    logic [N_CHANNELS-1:0] flit_empty;
    logic [N_CHANNELS-1:0] ts_full;
    logic [N_CHANNELS-1:0] push;
    logic [N_CHANNELS-1:0] flit_pop;
    logic [FLIT_SIZE:0]    flit_head [N_CHANNELS];

    rx_arb_state_t state_q, state_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [CW-1:0] last_grant_q, last_grant_d;
    logic [CW-1:0] pick;
    logic          found;
    logic          out_pop;
    logic          out_eop;

    // Credit is a pure function of storage state and reset, never of rx_i/eop_i.
    assign credit_o = ~flit_full & ~ts_full & {N_CHANNELS{~rst_i}};

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_flit
        assign push[c]     = rx_i[c] && credit_o[c];
        assign flit_pop[c] = out_pop && (grant_q == CW'(c));

        rx_channel_fifo #(
            .DATA_SIZE (FLIT_SIZE + 1),
            .DEPTH     (BUFFER_SIZE)
        ) u_flit_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[c]),
            .data_i  ({eop_i[c], data_i[c*FLIT_SIZE +: FLIT_SIZE]}),
            .pop_i   (flit_pop[c]),
            .data_o  (flit_head[c]),
            .full_o  (flit_full[c]),
            .empty_o (flit_empty[c])
        );
    end

`ifdef DMNI_RX_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts_head [N_CHANNELS];
    logic [N_CHANNELS-1:0] ts_empty_unused;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ts
        rx_channel_fifo #(
            .DATA_SIZE (TS_WIDTH),
            .DEPTH     (TS_DEPTH)
        ) u_ts_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[c] && eop_i[c]),
            .data_i  (tick_counter_i),
            .pop_i   (pkt_done_o && (grant_q == CW'(c))),
            .data_o  (ts_head[c]),
            .full_o  (ts_full[c]),
            .empty_o (ts_empty_unused[c])
        );
    end

    assign timestamp_o = ts_head[grant_q];
`else
    logic unused_tick;

    assign ts_full     = '0;
    assign timestamp_o = '0;
    assign unused_tick = ^tick_counter_i;
`endif

    assign out_eop    = flit_head[grant_q][FLIT_SIZE];
    assign data_o     = flit_head[grant_q][FLIT_SIZE-1:0];
    assign eop_o      = out_eop;
    assign tx_o       = (state_q == RX_LOCKED) && !flit_empty[grant_q];
    assign out_pop    = tx_o && ack_i;
    assign pkt_done_o = out_pop && out_eop;
    assign channel_o  = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pick         = grant_q;
        found        = 1'b0;

        // Round-robin: channels above last_grant first, then wrap from channel 0.
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!found && (CW'(i) > last_grant_q) && !flit_empty[i]) begin
                found = 1'b1;
                pick  = CW'(i);
            end
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!found && !flit_empty[i]) begin
                found = 1'b1;
                pick  = CW'(i);
            end
        end

        case (state_q)
            RX_IDLE: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = RX_LOCKED;
                end
            end
            RX_LOCKED: begin
                // Stay locked through starvation so packets never interleave.
                if (out_pop && out_eop) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RX_IDLE;
            grant_q      <= '0;
            last_grant_q <= CW'(N_CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_dmni_rx_buffer.sv
// Directed bench for dmni_rx_buffer: two channels, hand-computed flit order,
// cycle positions, channels and timestamps compared through one check task.
module tb_dmni_rx_buffer;

    localparam int N   = 2;
    localparam int FW  = 32;
    localparam int BS  = 16;
    localparam int TSD = 2;
    localparam int TW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   tick;
    logic [N-1:0]    rx;
    logic [N-1:0]    eop_in;
    logic [N-1:0]    credit;
    logic [N*FW-1:0] data_in;
    logic            tx;
    logic            eop_out;
    logic            ack;
    logic [FW-1:0]   data_out;
    logic [0:0]      channel;
    logic [TW-1:0]   ts_out;
    logic            pkt_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [FW-1:0] mon_data[$];
    int            mon_ch[$];
    int            mon_cyc[$];
    logic          mon_eop[$];
    logic [TW-1:0] mon_ts[$];

    logic [FW-1:0] exp_q[$];
    int            exp_ch_q[$];
    int            exp_off_q[$];
    logic          exp_eop_q[$];
    logic [TW-1:0] exp_ts_q[$];

    dmni_rx_buffer #(
        .N_CHANNELS  (N),
        .FLIT_SIZE   (FW),
        .BUFFER_SIZE (BS),
        .TS_DEPTH    (TSD),
        .TS_WIDTH    (TW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tick_counter_i (tick),
        .rx_i           (rx),
        .eop_i          (eop_in),
        .credit_o       (credit),
        .data_i         (data_in),
        .tx_o           (tx),
        .eop_o          (eop_out),
        .ack_i          (ack),
        .data_o         (data_out),
        .channel_o      (channel),
        .timestamp_o    (ts_out),
        .pkt_done_o     (pkt_done)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && tx && ack) begin
            mon_data.push_back(data_out);
            mon_ch.push_back(int'(channel));
            mon_cyc.push_back(cyc);
            mon_eop.push_back(eop_out);
            mon_ts.push_back(ts_out);
        end
        if (!rst && pkt_done) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] ts_model(input logic [TW-1:0] v);
`ifdef DMNI_RX_TIMESTAMP_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic e, input logic [FW-1:0] d);
        rx[c]              = v;
        eop_in[c]          = e;
        data_in[c*FW +: FW] = d;
    endtask

    task automatic clear_sb();
        mon_data.delete(); mon_ch.delete(); mon_cyc.delete(); mon_eop.delete(); mon_ts.delete();
        exp_q.delete(); exp_ch_q.delete(); exp_off_q.delete(); exp_eop_q.delete(); exp_ts_q.delete();
        done_cnt = 0;
    endtask

    task automatic add_exp(input logic [FW-1:0] d, input int ch, input logic e, input int off,
                           input logic [TW-1:0] ts);
        exp_q.push_back(d);
        exp_ch_q.push_back(ch);
        exp_eop_q.push_back(e);
        exp_off_q.push_back(off);
        exp_ts_q.push_back(ts_model(ts));
    endtask

    task automatic compare_stream(input string tag, input int base_cyc);
        check_val({tag, "_count"}, 64'(mon_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_data.size(); i++) begin
            check_val($sformatf("%s_data%0d", tag, i), 64'(mon_data[i]), 64'(exp_q[i]));
            check_val($sformatf("%s_ch%0d", tag, i), 64'(mon_ch[i]), 64'(exp_ch_q[i]));
            check_val($sformatf("%s_eop%0d", tag, i), 64'(mon_eop[i]), 64'(exp_eop_q[i]));
            check_val($sformatf("%s_cyc%0d", tag, i), 64'(mon_cyc[i]), 64'(base_cyc + exp_off_q[i]));
            if (exp_eop_q[i]) begin
                check_val($sformatf("%s_ts%0d", tag, i), 64'(mon_ts[i]), 64'(exp_ts_q[i]));
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; rx = '0; eop_in = '0; data_in = '0; ack = 1'b0;
        step();
        check_val({tag, "_credit_in_rst"}, 64'(credit), 64'(0));
        check_val({tag, "_tx"}, 64'(tx), 64'(0));
        check_val({tag, "_done"}, 64'(pkt_done), 64'(0));
        check_val({tag, "_channel"}, 64'(channel), 64'(0));
        rst = 1'b0;
        #1;
        check_val({tag, "_credit_after"}, 64'(credit), 64'(2'b11));
    endtask

    int t0;
    int sent;

    initial begin
        rst = 1'b1; tick = '0; rx = '0; eop_in = '0; data_in = '0; ack = 1'b0;
        step();
        do_reset("rst0");

        // single-channel 3-flit packet
        clear_sb();
        ack = 1'b1;
        step();
        t0 = cyc;
        set_ch(0, 1'b1, 1'b0, 32'hA); step();
        set_ch(0, 1'b1, 1'b0, 32'hB); step();
        tick = 32'd100;
        set_ch(0, 1'b1, 1'b1, 32'hC); step();
        set_ch(0, 1'b0, 1'b0, '0);
        repeat (6) step();
        add_exp(32'hA, 0, 1'b0, 2, '0);
        add_exp(32'hB, 0, 1'b0, 3, '0);
        add_exp(32'hC, 0, 1'b1, 4, 32'd100);
        compare_stream("single", t0);
        check_val("single_done", 64'(done_cnt), 64'(1));

        // atomicity and round-robin
        do_reset("rst1");
        clear_sb();
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) tick = 32'd204;
            set_ch(0, 1'b1, i == 3, 32'h100 + 32'(i));
            set_ch(1, 1'b1, i == 3, 32'h200 + 32'(i));
            step();
        end
        set_ch(0, 1'b0, 1'b0, '0);
        set_ch(1, 1'b0, 1'b0, '0);
        ack = 1'b1;
        t0 = cyc;
        repeat (5) step();
        set_ch(0, 1'b1, 1'b0, 32'h300); step();
        tick = 32'd306;
        set_ch(0, 1'b1, 1'b1, 32'h301); step();
        set_ch(0, 1'b0, 1'b0, '0);
        repeat (8) step();
        for (int i = 0; i < 4; i++) add_exp(32'h100 + 32'(i), 0, i == 3, i, 32'd204);
        for (int i = 0; i < 4; i++) add_exp(32'h200 + 32'(i), 1, i == 3, 5 + i, 32'd204);
        add_exp(32'h300, 0, 1'b0, 10, '0);
        add_exp(32'h301, 0, 1'b1, 11, 32'd306);
        compare_stream("rr", t0);
        check_val("rr_done", 64'(done_cnt), 64'(3));

        // backpressure up to full
        clear_sb();
        ack = 1'b0;
        tick = 32'd400;
        sent = 0;
        for (int k = 0; k < 20; k++) begin
            set_ch(0, 1'b1, sent == 15, 32'h1000 + 32'(sent));
            #1;
            if (credit[0]) sent++;
            step();
        end
        set_ch(0, 1'b0, 1'b0, '0);
        #1;
        check_val("bp_accepted", 64'(sent), 64'(16));
        check_val("bp_credit_full", 64'(credit[0]), 64'(0));
        ack = 1'b1;
        t0 = cyc;
        #1;
        check_val("bp_credit_first_pop", 64'(credit[0]), 64'(0));
        step();
        check_val("bp_credit_back", 64'(credit[0]), 64'(1));
        repeat (20) step();
        for (int i = 0; i < 16; i++) add_exp(32'h1000 + 32'(i), 0, i == 15, i, 32'd400);
        compare_stream("bp", t0);
        check_val("bp_done", 64'(done_cnt), 64'(1));

        // mid-packet starvation
        clear_sb();
        ack = 1'b1;
        t0 = cyc;
        set_ch(0, 1'b1, 1'b0, 32'h30); step();
        set_ch(0, 1'b1, 1'b0, 32'h31);
        set_ch(1, 1'b1, 1'b0, 32'h40); step();
        set_ch(0, 1'b0, 1'b0, '0);
        set_ch(1, 1'b1, 1'b0, 32'h41); step();
        tick = 32'd500;
        set_ch(1, 1'b1, 1'b1, 32'h42); step();
        set_ch(1, 1'b0, 1'b0, '0);
        for (int g = 0; g < 3; g++) begin
            #1;
            check_val($sformatf("starve_tx%0d", g), 64'(tx), 64'(0));
            check_val($sformatf("starve_ch%0d", g), 64'(channel), 64'(0));
            step();
        end
        tick = 32'd700;
        set_ch(0, 1'b1, 1'b1, 32'h32);
        #1;
        check_val("starve_tx3", 64'(tx), 64'(0));
        step();
        set_ch(0, 1'b0, 1'b0, '0);
        repeat (8) step();
        add_exp(32'h30, 0, 1'b0, 2, '0);
        add_exp(32'h31, 0, 1'b0, 3, '0);
        add_exp(32'h32, 0, 1'b1, 8, 32'd700);
        add_exp(32'h40, 1, 1'b0, 10, '0);
        add_exp(32'h41, 1, 1'b0, 11, '0);
        add_exp(32'h42, 1, 1'b1, 12, 32'd500);
        compare_stream("starve", t0);

`ifdef DMNI_RX_TIMESTAMP_EN
        // timestamp FIFO limit
        clear_sb();
        ack = 1'b0;
        t0 = cyc;
        tick = 32'd10;
        set_ch(0, 1'b1, 1'b1, 32'h51);
        #1; check_val("ts_credit0", 64'(credit[0]), 64'(1));
        step();
        tick = 32'd20;
        set_ch(0, 1'b1, 1'b1, 32'h52);
        #1; check_val("ts_credit1", 64'(credit[0]), 64'(1));
        step();
        tick = 32'd30;
        set_ch(0, 1'b1, 1'b1, 32'h53);
        #1; check_val("ts_credit2", 64'(credit[0]), 64'(0));
        step();
        #1; check_val("ts_credit3", 64'(credit[0]), 64'(0));
        step();
        ack = 1'b1;
        #1; check_val("ts_credit4", 64'(credit[0]), 64'(0));
        step();
        check_val("ts_credit5", 64'(credit[0]), 64'(1));
        step();
        set_ch(0, 1'b0, 1'b0, '0);
        repeat (8) step();
        add_exp(32'h51, 0, 1'b1, 4, 32'd10);
        add_exp(32'h52, 0, 1'b1, 6, 32'd20);
        add_exp(32'h53, 0, 1'b1, 8, 32'd30);
        compare_stream("tslim", t0);
        check_val("tslim_done", 64'(done_cnt), 64'(3));
`endif

        // reset while ch1 is locked
        clear_sb();
        ack = 1'b0;
        set_ch(1, 1'b1, 1'b0, 32'h61); step();
        set_ch(1, 1'b1, 1'b0, 32'h62); step();
        set_ch(1, 1'b1, 1'b0, 32'h63);
        #1;
        check_val("mid_pre_tx", 64'(tx), 64'(1));
        check_val("mid_pre_ch", 64'(channel), 64'(1));
        step();
        set_ch(1, 1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        check_val("mid_credit_in_rst", 64'(credit), 64'(0));
        step();
        rst = 1'b0;
        ack = 1'b1;
        #1;
        check_val("mid_tx_after", 64'(tx), 64'(0));
        check_val("mid_ch_after", 64'(channel), 64'(0));
        check_val("mid_credit_after", 64'(credit), 64'(2'b11));
        for (int g = 0; g < 3; g++) begin
            step();
            check_val($sformatf("mid_flush_tx%0d", g), 64'(tx), 64'(0));
        end
        check_val("mid_flush_count", 64'(mon_data.size()), 64'(0));
        clear_sb();
        t0 = cyc;
        set_ch(1, 1'b1, 1'b0, 32'h71); step();
        tick = 32'd800;
        set_ch(1, 1'b1, 1'b1, 32'h72); step();
        set_ch(1, 1'b0, 1'b0, '0);
        repeat (6) step();
        add_exp(32'h71, 1, 1'b0, 2, '0);
        add_exp(32'h72, 1, 1'b1, 3, 32'd800);
        compare_stream("post_rst", t0);
        check_val("post_rst_done", 64'(done_cnt), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmni_rx_buffer.md
# dmni_rx_buffer

Multi-channel receive front-end for the DMNI. It generalises the single Hermes input buffer and its packet-timestamp buffer to `N_CHANNELS` independent Hermes input ports. Each channel has its own flit FIFO and its own per-packet timestamp FIFO. A packet-atomic round-robin arbiter merges the channels onto one DMA-side stream, and no two packets are ever interleaved.

## Interface
Parameters:
- `N_CHANNELS`, default 2: number of Hermes input ports; must be ≥1.
- `FLIT_SIZE`, default 32: Hermes flit width.
- `BUFFER_SIZE`, default 16: flit FIFO depth per channel; must be a power of two and ≥2.
- `TS_DEPTH`, default max(2, BUFFER_SIZE/4): timestamp FIFO depth per channel; must be a power of two.
- `TS_WIDTH`, default 32: width of the tick counter and timestamps.

Ports (clock and reset first):
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tick_counter_i`  in  TS_WIDTH  free-running time base.
- `rx_i`  in  N_CHANNELS  per-channel flit valid.
- `eop_i`  in  N_CHANNELS  per-channel end-of-packet flag.
- `credit_o`  out  N_CHANNELS  per-channel credit (ready).
- `data_i`  in  N_CHANNELS×FLIT_SIZE  per-channel flit data.
- `tx_o`  out  1  output flit valid.
- `eop_o`  out  1  output flit is the last flit of its packet.
- `ack_i`  in  1  DMA accepts the output flit.
- `data_o`  out  FLIT_SIZE  output flit.
- `channel_o`  out  max(1,$clog2(N_CHANNELS))  channel currently granted.
- `timestamp_o`  out  TS_WIDTH  timestamp of the granted packet.
- `pkt_done_o`  out  1  pulse when the EOP flit is consumed at the output.

## Operation
- **Push.** A flit on channel c is accepted when `rx_i[c] && credit_o[c]`. `{eop_i[c], data_i[c]}` is written to the channel-c flit FIFO.
- **Credit.** `credit_o[c] = !flit_full[c] && !ts_full[c] && !rst_i`.
- **Timestamp capture.** When an accepted flit has `eop_i[c]=1`, `tick_counter_i` is pushed into the channel-c TS FIFO in the same cycle.
- **Arbiter states.**
  - IDLE: if any flit FIFO is non-empty, grant the first non-empty channel searching from `last_grant+1` modulo N_CHANNELS. The grant and `last_grant` are registered, and the next state is LOCKED. If all FIFOs are empty, stay in IDLE.
  - LOCKED: `tx_o = !flit_empty[grant]`, and `data_o`/`eop_o` come from the FIFO head. A flit is popped on `tx_o && ack_i`. If the granted FIFO runs empty mid-packet, `tx_o` drops and the arbiter stays LOCKED; other channels wait.
  - LOCKED → IDLE: on a popped flit with `eop_o=1`. In that cycle the TS FIFO head is popped and `pkt_done_o`=1.
- **Timestamp output.** `timestamp_o` shows the TS FIFO head of the granted channel. It is guaranteed valid whenever `tx_o && eop_o`.
- **Idle outputs.** In IDLE, `tx_o=0` and `data_o`/`eop_o` are don't-care.
- **FIFO pointers.** Pointers are $clog2(depth)+1 bits and wrap naturally.
  - Full when the MSBs differ and the lower bits are equal.
  - Empty when all bits are equal.
  - Push and pop in the same cycle are legal on a FIFO that is neither full nor empty; the occupancy is unchanged.
- **Single-flit packets** (EOP on the first flit) are legal.
- **Timestamps** wrap modulo 2^TS_WIDTH with no saturation.

## Timing
- **Reset.** `rst_i` sampled high for one edge:
  - all pointers are 0, state is IDLE, `last_grant` = N_CHANNELS-1 (so channel 0 wins first);
  - `tx_o`=0, `pkt_done_o`=0, `channel_o`=0;
  - `credit_o`=0 while `rst_i`=1 and all ones the cycle after.
- **Reset mid-packet.** Stored flits and timestamps are discarded. No partial packet is emitted after reset.
- **Latency.** A flit accepted at edge k into an idle block gives `tx_o`=1 at cycle k+2: k+1 is the IDLE grant cycle, k+2 is LOCKED.
- **Throughput.** One flit per cycle within a packet. There is exactly one bubble cycle (IDLE) between packets.
- **Combinational paths.** `credit_o` does not depend on `rx_i` or `eop_i`. `data_o`, `eop_o` and `timestamp_o` do not depend on `ack_i`. `pkt_done_o` is combinational from `tx_o && ack_i && eop_o`.

## Configuration
- Macro `DMNI_RX_TIMESTAMP_EN`.
- **Defined:** TS FIFOs are instantiated and behave as above.
- **Undefined:**
  - no TS FIFOs are built;
  - `timestamp_o` is tied to 0;
  - `ts_full` is treated as 0, so credit depends only on the flit FIFO;
  - `tick_counter_i` is unused, with its lint waiver.

## Structure
- **Shared package `DMNIPkg`:**
  - arbiter state enum `rx_arb_state_t` {RX_IDLE, RX_LOCKED};
  - the channel-index width helper function.
- **Sub-module `rx_channel_fifo`:** a generic FIFO with parameters DATA_SIZE and DEPTH and a synchronous active-high reset.
  - Instantiated N_CHANNELS times for flits (DATA_SIZE = FLIT_SIZE+1).
  - Instantiated N_CHANNELS times for timestamps (DATA_SIZE = TS_WIDTH) under the macro.
- **Top level:** the arbiter, credit logic and output mux.

## Test plan
- **Single channel:** N=2. Send a 3-flit packet 0xA,0xB,0xC(eop) on ch0 with `tick_counter_i`=100 at the EOP push and `ack_i`=1. Required: `tx_o` rises 2 cycles after the first push; flits appear in order on consecutive cycles; `timestamp_o`=100 on 0xC; `pkt_done_o` pulses once; `channel_o`=0.
- **Packet atomicity and round-robin:** ch0 and ch1 each hold a 4-flit packet before the first grant. Required: ch0's 4 flits, then one idle cycle, then ch1's 4 flits, with no interleaving. A following ch0 packet arriving while ch1 is active is served after ch1.
- **Backpressure and full:** BUFFER_SIZE=16, `ack_i`=0, ch0 offers 20 flits. Required: `credit_o[0]`=0 after 16 accepted and exactly 16 stored. Raising `ack_i` drains all 16 in order; credit returns the cycle after the first pop.
- **Mid-packet starvation:** ch0 sends 2 flits, pauses 5 cycles, then sends the EOP; ch1 has a full packet waiting. Required: `tx_o`=0 during the gap, `channel_o` stays 0, and ch1 is served only after ch0's EOP.
- **TS FIFO limit:** TS_DEPTH=2, `ack_i`=0, ch0 sends three 1-flit packets. Required: `credit_o[0]`=0 after the second EOP. The third packet is accepted only after the first `pkt_done_o`.
- **Reset mid-operation:** assert `rst_i` while ch1 is LOCKED with 3 flits queued. Required: `tx_o`=0 the next cycle, the FIFOs read empty, and a new ch1 packet is emitted cleanly with `channel_o`=1 and correct data.
